// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI burst register slave:
//   - state_e     : frame-level state of the slave (CMD, TURN, RD, WR)
//   - WR_BIT      : command bit selecting write (1) or read (0)
//   - ADDR_LSB    : lowest bit of the start-address field in the command word
//   - LEN_W       : width of the burst-length field (burst = LEN+1 words)
//   - len_lsb()   : bit offset of the LEN field for a given address width
// -----------------------------------------------------------------------------
package spi_reg_pkg;

    typedef enum logic [1:0] {
        CMD  = 2'd0,
        TURN = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_e;

    localparam int WR_BIT   = 0;
    localparam int ADDR_LSB = 1;
    localparam int LEN_W    = 8;

    // LEN sits directly above the address field.
    function automatic int len_lsb(input int addr_w);
        return ADDR_LSB + addr_w;
    endfunction

endpackage

// File: rtl/spi_shift_word.sv
// -----------------------------------------------------------------------------
// spi_shift_word
// DATA_W-bit MSB-first shift register with a bit counter. Used for the command
// word, received write data and transmitted read data. A load overrides a
// shift and restarts the bit count.
//
// Ports:
//   i_clk         SPI clock (rising edge)
//   i_rst         asynchronous active-high reset
//   i_shift_en    shift one bit in from i_sdi this cycle
//   i_load        parallel load of i_load_data, bit count restarts at 0
//   i_load_data   word to load
//   i_sdi         serial input bit
//   o_msb         current MSB of the shifter (serial output bit)
//   o_word_in     shifter contents including the bit being shifted in now
//   o_word_last   word-done pulse: this shift completes a DATA_W-bit word
// -----------------------------------------------------------------------------
module spi_shift_word #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_shift_en,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_sdi,
    output logic              o_msb,
    output logic [DATA_W-1:0] o_word_in,
    output logic              o_word_last
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_cnt;

    assign o_msb       = r_sh[DATA_W-1];
    assign o_word_in   = {r_sh[DATA_W-2:0], i_sdi};
    assign o_word_last = i_shift_en & (r_cnt == CNT_W'(DATA_W - 1));

    // Shifter and bit counter; the counter wraps to 0 on each completed word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh  <= {DATA_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_sh  <= i_load_data;
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_shift_en) begin
            r_sh  <= o_word_in;
            r_cnt <= o_word_last ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
        end else begin
            r_sh  <= r_sh;
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/spi_reg_burst_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_burst_slave
// SPI slave register port with burst access. A DATA_W-bit command word gives
// the direction (bit 0), start address (bits ADDR_W:1) and burst length LEN
// (next 8 bits, burst = LEN+1 words). Data words then stream in (write) or out
// (read, after one turnaround bit) with no gaps. Chip select high resets the
// whole block, discarding any partial command or word.
//
// Ports:
//   sck_i    SPI clock, all logic on its rising edge
//   scs_i    chip select, active-high asynchronous reset
//   sdi_i    serial data in, MSB first
//   sdo_o    serial data out, MSB first; 0 outside of read data
//   addr_o   register address of the current access
//   rdata_i  read data, combinational function of addr_o
//   wdata_o  write data
//   we_o     one-cycle write strobe
//   re_o     one-cycle read strobe (cycle in which rdata_i was captured)
//
// Build option:
//   SPI_REG_BURST_AUTOINC_EN  defined   -> address increments per word
//                             undefined -> address fixed at the start address
// -----------------------------------------------------------------------------
module spi_reg_burst_slave
    import spi_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              sck_i,
    input  logic              scs_i,
    input  logic              sdi_i,
    output logic              sdo_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic              re_o
);

    localparam int LEN_LSB = len_lsb(ADDR_W);

    if (DATA_W < ADDR_W + 9) begin : g_bad_width
        $error("spi_reg_burst_slave: DATA_W must be at least ADDR_W+9");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_shift_en;
    logic              w_load;
    logic              w_cmd_done;
    logic              w_we_nxt;
    logic              w_re_nxt;
    logic              w_burst_dec;
    logic              w_msb;
    logic              w_word_last;
    logic [DATA_W-1:0] w_word_in;
    logic [LEN_W-1:0]  r_burst;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_re;
    logic              w_burst_zero;

    spi_shift_word #(
        .DATA_W (DATA_W)
    ) u_shift (
        .i_clk       (sck_i),
        .i_rst       (scs_i),
        .i_shift_en  (w_shift_en),
        .i_load      (w_load),
        .i_load_data (rdata_i),
        .i_sdi       (sdi_i),
        .o_msb       (w_msb),
        .o_word_in   (w_word_in),
        .o_word_last (w_word_last)
    );

    assign w_burst_zero = (r_burst == {LEN_W{1'b0}});

    // The shifter MSB is only meaningful as read data while in RD.
    assign sdo_o   = (r_state == RD) ? w_msb : 1'b0;
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign we_o    = r_we;
    assign re_o    = r_re;

    // Frame state register.
    always_ff @(posedge sck_i or posedge scs_i) begin
        if (scs_i) begin
            r_state <= CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_cmd_done  = 1'b0;
        w_we_nxt    = 1'b0;
        w_re_nxt    = 1'b0;
        w_burst_dec = 1'b0;
        case (r_state)
            CMD: begin
                w_shift_en = 1'b1;
                if (w_word_last) begin
                    w_cmd_done  = 1'b1;
                    w_state_nxt = w_word_in[WR_BIT] ? WR : TURN;
                end else begin
                    w_state_nxt = CMD;
                end
            end
            TURN: begin
                // sdi_i is ignored here; the first read word is captured.
                w_load      = 1'b1;
                w_re_nxt    = 1'b1;
                w_state_nxt = RD;
            end
            RD: begin
                w_shift_en = 1'b1;
                if (w_word_last) begin
                    if (w_burst_zero) begin
                        w_state_nxt = CMD;
                    end else begin
                        // Back-to-back reload: next MSB follows the LSB directly.
                        w_load      = 1'b1;
                        w_re_nxt    = 1'b1;
                        w_burst_dec = 1'b1;
                    end
                end else begin
                    w_state_nxt = RD;
                end
            end
            WR: begin
                w_shift_en = 1'b1;
                if (w_word_last) begin
                    w_we_nxt = 1'b1;
                    if (w_burst_zero) begin
                        w_state_nxt = CMD;
                    end else begin
                        w_burst_dec = 1'b1;
                    end
                end else begin
                    w_state_nxt = WR;
                end
            end
            default: begin
                w_state_nxt = CMD;
            end
        endcase
    end

    // Strobes, write data and burst down-counter.
    always_ff @(posedge sck_i or posedge scs_i) begin
        if (scs_i) begin
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_wdata <= {DATA_W{1'b0}};
            r_burst <= {LEN_W{1'b0}};
        end else begin
            r_we <= w_we_nxt;
            r_re <= w_re_nxt;
            if (w_we_nxt) begin
                r_wdata <= w_word_in;
            end else begin
                r_wdata <= r_wdata;
            end
            if (w_cmd_done) begin
                r_burst <= w_word_in[LEN_LSB +: LEN_W];
            end else if (w_burst_dec) begin
                r_burst <= r_burst - LEN_W'(1);
            end else begin
                r_burst <= r_burst;
            end
        end
    end

`ifdef SPI_REG_BURST_AUTOINC_EN
    // Address: loaded from the command, advanced the cycle after each strobe.
    always_ff @(posedge sck_i or posedge scs_i) begin
        if (scs_i) begin
            r_addr <= {ADDR_W{1'b0}};
        end else if (w_cmd_done) begin
            r_addr <= w_word_in[ADDR_LSB +: ADDR_W];
        end else if (r_we || r_re) begin
            r_addr <= r_addr + ADDR_W'(1);
        end else begin
            r_addr <= r_addr;
        end
    end
`else
    // Address: loaded from the command and held for the whole burst.
    always_ff @(posedge sck_i or posedge scs_i) begin
        if (scs_i) begin
            r_addr <= {ADDR_W{1'b0}};
        end else if (w_cmd_done) begin
            r_addr <= w_word_in[ADDR_LSB +: ADDR_W];
        end else begin
            r_addr <= r_addr;
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_burst_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_burst_slave
// Scoreboard bench: stimulus tasks push expected write/read events into
// queues; a negedge monitor pops and compares on every we_o / re_o and
// reassembles the serial read word from sdo_o.
// -----------------------------------------------------------------------------
module tb_spi_reg_burst_slave;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          sck_i;
    logic          scs_i;
    logic          sdi_i;
    logic          sdo_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] rdata_i;
    logic [DW-1:0] wdata_o;
    logic          we_o;
    logic          re_o;

    logic [DW-1:0] mem [16];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t wr_q[$];
    ev_t rd_q[$];

    int checks   = 0;
    int failures = 0;

    // Monitor state for reassembling a read word.
    int            rem = 0;
    logic [DW-1:0] rx_word;
    logic [DW-1:0] rx_exp;

    spi_reg_burst_slave #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .sck_i   (sck_i),
        .scs_i   (scs_i),
        .sdi_i   (sdi_i),
        .sdo_o   (sdo_o),
        .addr_o  (addr_o),
        .rdata_i (rdata_i),
        .wdata_o (wdata_o),
        .we_o    (we_o),
        .re_o    (re_o)
    );

    assign rdata_i = mem[addr_o];

    initial begin
        sck_i = 1'b0;
        forever #5 sck_i = ~sck_i;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int start, input int i);
`ifdef SPI_REG_BURST_AUTOINC_EN
        return AW'(start + i);
`else
        return AW'(start + 0 * i);
`endif
    endfunction

    function automatic logic [DW-1:0] mk_cmd(input logic [DW-1:0] hi, input int start,
                                             input int len, input logic wr);
        logic [DW-1:0] c;
        c = hi;
        c[0]   = wr;
        c[4:1] = start[3:0];
        c[12:5] = len[7:0];
        return c;
    endfunction

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) begin
            sdi_i = w[i];
            @(negedge sck_i);
        end
    endtask

    task automatic frame_begin();
        @(negedge sck_i);
        scs_i = 1'b0;
    endtask

    task automatic frame_end();
        @(negedge sck_i);
        scs_i = 1'b1;
        sdi_i = 1'b0;
        repeat (2) @(negedge sck_i);
    endtask

    // Write burst: word i carries seed + i*0x01010101.
    task automatic write_burst(input logic [DW-1:0] hi, input int start, input int len,
                               input logic [DW-1:0] seed);
        ev_t e;
        for (int i = 0; i <= len; i++) begin
            e.addr = exp_addr(start, i);
            e.data = seed + DW'(i) * 32'h0101_0101;
            wr_q.push_back(e);
        end
        send_word(mk_cmd(hi, start, len, 1'b1));
        for (int i = 0; i <= len; i++) begin
            send_word(seed + DW'(i) * 32'h0101_0101);
        end
    endtask

    task automatic read_burst(input int start, input int len);
        ev_t e;
        for (int i = 0; i <= len; i++) begin
            e.addr = exp_addr(start, i);
            e.data = mem[e.addr];
            rd_q.push_back(e);
        end
        send_word(mk_cmd(32'h0, start, len, 1'b0));
        sdi_i = 1'b0;
        repeat (1 + DW * (len + 1)) @(negedge sck_i);
    endtask

    task automatic queues_drained(input string name);
        chk({name, "_wr_left"}, DW'(wr_q.size()), 32'd0);
        chk({name, "_rd_left"}, DW'(rd_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: strobes, read-word reassembly, idle sdo_o.
    always @(negedge sck_i) begin
        ev_t e;
        if (we_o) begin
            if (wr_q.size() == 0) begin
                chk("we_unexpected", {31'b0, we_o}, 32'd0);
            end else begin
                e = wr_q.pop_front();
                chk("we_addr", {28'b0, addr_o}, {28'b0, e.addr});
                chk("we_data", wdata_o, e.data);
            end
        end
        if (re_o) begin
            if (rd_q.size() == 0) begin
                chk("re_unexpected", {31'b0, re_o}, 32'd0);
                rx_exp = 32'h0;
            end else begin
                e = rd_q.pop_front();
                chk("re_addr", {28'b0, addr_o}, {28'b0, e.addr});
                rx_exp = e.data;
            end
            rx_word = {31'b0, sdo_o};
            rem     = DW - 1;
        end else if (rem > 0) begin
            rx_word = {rx_word[DW-2:0], sdo_o};
            rem     = rem - 1;
            if (rem == 0) begin
                chk("sdo_word", rx_word, rx_exp);
            end
        end else begin
            chk("sdo_idle", {31'b0, sdo_o}, 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = DW'(i) * 32'h0F0F_0F0F;
        end
        mem[2] = 32'h1234_5678;
        mem[5] = 32'hCAFE_0005;
        mem[6] = 32'h5A5A_A5A5;
        mem[7] = 32'h8000_0001;

        scs_i = 1'b0;
        sdi_i = 1'b0;
        #2 scs_i = 1'b1;
        repeat (3) @(negedge sck_i);
        chk("rst_sdo",   {31'b0, sdo_o},  32'd0);
        chk("rst_addr",  {28'b0, addr_o}, 32'd0);
        chk("rst_wdata", wdata_o,         32'd0);
        chk("rst_we",    {31'b0, we_o},   32'd0);
        chk("rst_re",    {31'b0, re_o},   32'd0);

        // Single write (cmd 0x7) then back-to-back single read (cmd 0x4).
        frame_begin();
        write_burst(32'h0, 3, 0, 32'hDEAD_BEEF);
        read_burst(2, 0);
        frame_end();
        queues_drained("single");

        // Burst write addr 14, LEN 3 (wraps 15 -> 0 with auto-increment).
        frame_begin();
        write_burst(32'h0, 14, 3, 32'hA000_000A);
        frame_end();
        queues_drained("wr_wrap");

        // Burst read addr 5, LEN 2, contiguous words.
        frame_begin();
        read_burst(5, 2);
        frame_end();
        queues_drained("rd_burst");

        // Abort after 20 data bits of a write: no strobe, outputs reset.
        frame_begin();
        send_word(mk_cmd(32'h0, 3, 0, 1'b1));
        for (int i = DW - 1; i >= DW - 20; i--) begin
            sdi_i = ~i[0];
            @(negedge sck_i);
        end
        scs_i = 1'b1;
        #1;
        chk("abort_sdo",   {31'b0, sdo_o},  32'd0);
        chk("abort_addr",  {28'b0, addr_o}, 32'd0);
        chk("abort_wdata", wdata_o,         32'd0);
        chk("abort_we",    {31'b0, we_o},   32'd0);
        chk("abort_re",    {31'b0, re_o},   32'd0);
        repeat (2) @(negedge sck_i);

        // Next frame works normally; upper command bits are ignored.
        frame_begin();
        write_burst(32'hABC0_0000, 5, 0, 32'h0BAD_F00D);
        frame_end();
        queues_drained("after_abort");

        // Burst write addr 9, LEN 2 (fixed address without auto-increment).
        frame_begin();
        write_burst(32'h0, 9, 2, 32'h9000_0009);
        frame_end();
        queues_drained("wr_addr9");

        // Maximum burst: LEN 255 gives 256 words.
        frame_begin();
        write_burst(32'h0, 0, 255, 32'h0000_1000);
        frame_end();
        queues_drained("wr_len255");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
